core_ctrl: RTL and testbench



---
 rtl/core_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_core_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// Instruction sequencer for the single-core NPU: Q/K load, kernel load, MAC execute,
// OFIFO drain to PSUM, and (with CORE_CTRL_SFP_EN defined) SFP accumulate/divide.
module core_ctrl #(
    parameter int col       = 8,
    parameter int bw        = 8,
    parameter int pr        = 8,
    parameter int len       = 8,
    parameter int DRAIN_CYC = 16,
    parameter int SFP_LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [pr*bw-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [19:0]      inst,
    output logic [pr*bw-1:0] mem_in,
    output logic             busy,
    output logic             done
);

    if (len < 1 || len > 16) begin : g_len_chk
        $error("core_ctrl: len must be in 1..16");
    end
    if (col < 1 || col > 16) begin : g_col_chk
        $error("core_ctrl: col must be in 1..16");
    end
    if (DRAIN_CYC < 1 || DRAIN_CYC > 32) begin : g_drain_chk
        $error("core_ctrl: DRAIN_CYC must be in 1..32");
    end
    if (SFP_LAT < 1 || SFP_LAT > 30) begin : g_lat_chk
        $error("core_ctrl: SFP_LAT must be in 1..30");
    end

    localparam logic [4:0] LEN5       = 5'(len);
    localparam logic [4:0] LEN_LAST   = 5'(len - 1);
    localparam logic [4:0] COL5       = 5'(col);
    localparam logic [4:0] COL_LAST   = 5'(col - 1);
    localparam logic [4:0] DRAIN_LAST = 5'(DRAIN_CYC - 1);
`ifdef CORE_CTRL_SFP_EN
    localparam logic [4:0] LAT_LAST   = 5'(SFP_LAT + 1);
`endif

    typedef enum logic [3:0] {
        IDLE,
        QLOAD,
        KLOAD,
        KTOARR,
        EXEC,
        DRAIN,
        PWRITE,
`ifdef CORE_CTRL_SFP_EN
        SFPACC,
        SFPDIV,
`endif
        DONE
    } state_t;

    state_t             state, state_next;
    logic [4:0]         cnt, cnt_next;
    logic [19:0]        inst_next;
    logic [pr*bw-1:0]   mem_next;
    logic               xfer;
`ifdef CORE_CTRL_SFP_EN
    logic [4:0]         row, row_next;
`endif

    assign in_ready = (state == QLOAD) || (state == KLOAD);
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            inst   <= '0;
            mem_in <= '0;
`ifdef CORE_CTRL_SFP_EN
            row    <= '0;
`endif
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            inst   <= inst_next;
            mem_in <= mem_next;
`ifdef CORE_CTRL_SFP_EN
            row    <= row_next;
`endif
        end
    end

    // inst/mem_in are computed here and registered, so each word appears one cycle after its state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        inst_next  = '0;
        mem_next   = '0;
`ifdef CORE_CTRL_SFP_EN
        row_next   = row;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = QLOAD;
                    cnt_next   = '0;
                end
            end
            QLOAD: begin
                if (xfer) begin
                    inst_next        = 20'h00010;
                    inst_next[15:12] = cnt[3:0];
                    mem_next         = in_data;
                    if (cnt == LEN_LAST) begin
                        state_next = KLOAD;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 5'd1;
                    end
                end
            end
            KLOAD: begin
                if (xfer) begin
                    inst_next        = 20'h00004;
                    inst_next[15:12] = cnt[3:0];
                    mem_next         = in_data;
                    if (cnt == COL_LAST) begin
                        state_next = KTOARR;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 5'd1;
                    end
                end
            end
            KTOARR: begin
                // The trailing select-only cycle covers the kmem read latency.
                if (cnt < COL5) begin
                    inst_next        = 20'h00048;
                    inst_next[15:12] = cnt[3:0];
                    cnt_next         = cnt + 5'd1;
                end else begin
                    inst_next  = 20'h00040;
                    state_next = EXEC;
                    cnt_next   = '0;
                end
            end
            EXEC: begin
                if (cnt < LEN5) begin
                    inst_next        = 20'h000A0;
                    inst_next[15:12] = cnt[3:0];
                    cnt_next         = cnt + 5'd1;
                end else begin
                    inst_next  = 20'h00080;
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_next = PWRITE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
            PWRITE: begin
                // OFIFO read in cycle i lands in PSUM row i-1 one cycle later.
                if (cnt < LEN5) begin
                    inst_next[16] = 1'b1;
                end
                if (cnt != 5'd0) begin
                    inst_next[0]    = 1'b1;
                    inst_next[11:8] = cnt[3:0] - 4'd1;
                end
                if (cnt == LEN5) begin
`ifdef CORE_CTRL_SFP_EN
                    state_next = SFPACC;
`else
                    state_next = DONE;
`endif
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
`ifdef CORE_CTRL_SFP_EN
            SFPACC: begin
                if (cnt < LEN5) begin
                    inst_next[1]    = 1'b1;
                    inst_next[11:8] = cnt[3:0];
                end
                if (cnt != 5'd0) begin
                    inst_next[17] = 1'b1;
                end
                if (cnt == LEN5) begin
                    state_next = SFPDIV;
                    cnt_next   = '0;
                    row_next   = '0;
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
            SFPDIV: begin
                // Rows run serially so the PSUM read and write-back never share a cycle.
                if (cnt == 5'd0) begin
                    inst_next[1]    = 1'b1;
                    inst_next[11:8] = row[3:0];
                end else if (cnt == 5'd1) begin
                    inst_next[18] = 1'b1;
                end else if (cnt == LAT_LAST) begin
                    inst_next[19]   = 1'b1;
                    inst_next[0]    = 1'b1;
                    inst_next[11:8] = row[3:0];
                end
                if (cnt == LAT_LAST) begin
                    cnt_next = '0;
                    if (row == LEN_LAST) begin
                        state_next = DONE;
                    end else begin
                        row_next = row + 5'd1;
                    end
                end else begin
                    cnt_next = cnt + 5'd1;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl with default parameters; expected instruction streams
// are built from the sequencing rules (SFP phases included when CORE_CTRL_SFP_EN is defined).
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [19:0] inst;
    logic [63:0] mem_in;
    logic        busy;
    logic        done;

    int passCount  = 0;
    int checkCount = 0;
    int busyCount  = 0;
    int doneCount  = 0;
    logic [19:0] expQ[$];

    core_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inst     (inst),
        .mem_in   (mem_in),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Advance one cycle and sample outputs 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
        if (busy) busyCount++;
        if (done) doneCount++;
    endtask

    task automatic buildExpected;
        logic [19:0] w;
        expQ.delete();
        for (int i = 0; i < 8; i++) expQ.push_back(20'h00048 | 20'(i << 12));
        expQ.push_back(20'h00040);
        for (int i = 0; i < 8; i++) expQ.push_back(20'h000A0 | 20'(i << 12));
        expQ.push_back(20'h00080);
        for (int i = 0; i < 16; i++) expQ.push_back(20'h00000);
        for (int i = 0; i <= 8; i++) begin
            w = 20'h0;
            if (i < 8) w = w | 20'h10000;
            if (i >= 1) w = w | 20'h00001 | 20'((i - 1) << 8);
            expQ.push_back(w);
        end
`ifdef CORE_CTRL_SFP_EN
        for (int i = 0; i <= 8; i++) begin
            w = 20'h0;
            if (i < 8) w = w | 20'h00002 | 20'(i << 8);
            if (i >= 1) w = w | 20'h20000;
            expQ.push_back(w);
        end
        for (int r = 0; r < 8; r++) begin
            expQ.push_back(20'h00002 | 20'(r << 8));
            expQ.push_back(20'h40000);
            expQ.push_back(20'h80001 | 20'(r << 8));
        end
`endif
    endtask

    // One pass: optional 3-cycle stall after Q vector index stallAfter, optional reset
    // at phase cycle abortAt (13 = EXEC cycle 4).
    task automatic applyStimulus(input int stallAfter, input int abortAt);
        logic [63:0] vec;
        int violations;
        int expBusy;
        busyCount = 0;
        doneCount = 0;
        violations = 0;
        start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("busyAfterStart", busy, 1);
        checkOutput("readyAfterStart", in_ready, 1);
        checkOutput("instAfterStart", inst, 0);
        for (int k = 0; k < 8; k++) begin
            vec = {8{8'(k + 1)}};
            in_valid = 1'b1;
            in_data = vec;
            tick;
            checkOutput("qInst", inst, 20'h00010 | 20'(k << 12));
            checkOutput("qData", mem_in, vec);
            if (k == stallAfter) begin
                in_valid = 1'b0;
                repeat (3) begin
                    tick;
                    checkOutput("stallInst", inst, 0);
                    checkOutput("stallReady", in_ready, 1);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            vec = {8{8'(k + 9)}};
            in_valid = 1'b1;
            in_data = vec;
            tick;
            checkOutput("kInst", inst, 20'h00004 | 20'(k << 12));
            checkOutput("kData", mem_in, vec);
        end
        in_valid = 1'b0;
        checkOutput("readyDrop", in_ready, 0);
        buildExpected();
        for (int j = 0; j < expQ.size(); j++) begin
            if (j == abortAt) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                checkOutput("abortInst", inst, 0);
                checkOutput("abortMem", mem_in, 0);
                checkOutput("abortBusy", busy, 0);
                checkOutput("abortReady", in_ready, 0);
                return;
            end
            tick;
            checkOutput("phaseInst", inst, expQ[j]);
            checkOutput("phaseBusy", busy, (j < expQ.size() - 1) ? 1 : 0);
            checkOutput("phaseDone", done, (j == expQ.size() - 1) ? 1 : 0);
            if (inst[1] && inst[0]) violations++;
        end
        tick;
        checkOutput("idleInst", inst, 0);
        checkOutput("idleDone", done, 0);
        checkOutput("idleBusy", busy, 0);
        expBusy = 59;
`ifdef CORE_CTRL_SFP_EN
        expBusy = 92;
`endif
        if (stallAfter >= 0) expBusy = expBusy + 3;
        checkOutput("busyCycles", 64'(busyCount), 64'(expBusy));
        checkOutput("donePulses", 64'(doneCount), 1);
        checkOutput("pmemPort", 64'(violations), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) begin
            in_valid = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            in_data = {$urandom, $urandom};
            tick;
            checkOutput("resetInst", inst, 0);
            checkOutput("resetMem", mem_in, 0);
            checkOutput("resetBusy", busy, 0);
            checkOutput("resetDone", done, 0);
            checkOutput("resetReady", in_ready, 0);
        end
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        reset = 1'b0;
        applyStimulus(3, -1);
        applyStimulus(-1, 13);
        applyStimulus(-1, -1);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
